// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
//   Shared types for the multi-cycle wide adder/subtractor.
//   - op_t    : requested operation (ADD / SUB)
//   - state_t : sequencer state (IDLE / RUN / DONE)
//   - init_carry() : carry value loaded into limb 0 at accept time
// -----------------------------------------------------------------------------
package adder_seq_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subtraction is a + ~b + 1, so the "+1" rides in on the limb-0 carry and
  // the caller's carry-in is ignored for SUB.
  function automatic logic init_carry(input op_t op, input logic cin);
    return (op == SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
//   Single N-bit ripple-free combinational adder with carry in/out. This is
//   the only arithmetic element in adder_seq; it is reused once per limb.
// Ports:
//   i_a, i_b  : N-bit addends
//   i_cin     : carry in
//   o_sum     : N-bit sum
//   o_cout    : carry out of bit N-1
// -----------------------------------------------------------------------------
module adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

endmodule

// File: rtl/adder_seq.sv
// -----------------------------------------------------------------------------
// adder_seq
//   Multi-cycle W = N*LIMBS bit adder/subtractor. One N-bit adder is walked
//   across the operand limbs, least-significant first, with the carry held in
//   a register between limbs. One operation is accepted per valid/ready
//   handshake; the result is held until downstream accepts it.
//
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_valid      : request valid
//   o_ready      : block can accept a request (IDLE)
//   i_op         : ADD / SUB
//   i_a, i_b     : W-bit operands, sampled only at the accept handshake
//   i_carry_in   : carry into limb 0 (ADD only)
//   o_valid      : result valid (DONE)
//   i_ready      : downstream accepts result
//   o_c          : W-bit sum / difference
//   o_carry_out  : carry out of the top limb (SUB: 1 = no borrow)
//   o_busy       : operation in flight (not IDLE)
//
// Timing: accept in cycle T, limbs processed in T+1..T+LIMBS, o_valid from
// T+LIMBS+1. Handshake signals are pure decodes of the state register.
// -----------------------------------------------------------------------------
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int N     = 64,
  parameter int LIMBS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  op_t                i_op,
  input  logic [N*LIMBS-1:0] i_a,
  input  logic [N*LIMBS-1:0] i_b,
  input  logic               i_carry_in,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N*LIMBS-1:0] o_c,
  output logic               o_carry_out,
  output logic               o_busy
);

  localparam int W     = N * LIMBS;
  localparam int IDX_W = $clog2(LIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic                    r_carry_out;
  logic [LIMBS-1:0][N-1:0] r_a;
  logic [LIMBS-1:0][N-1:0] r_b;
  logic [LIMBS-1:0][N-1:0] r_c;

  logic                    w_accept;
  logic [N-1:0]            w_sum;
  logic                    w_cout;

  assign w_accept = i_valid && (r_state == IDLE);

  // The limb index selects which slice of the captured operands feeds the
  // shared adder this cycle; it is only advanced in RUN and stops at LAST_IDX.
  adder #(.N(N)) u_adder (
    .i_a    (r_a[r_idx]),
    .i_b    (r_b[r_idx]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Captured operands are pure data: they are only meaningful between accept
  // and DONE, and the control path never reads them, so they carry no reset.
  // b is inverted here for SUB so the adder sees a + ~b + 1.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_a <= i_a;
      r_b <= (i_op == SUB) ? ~i_b : i_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_c         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_idx   <= '0;
            r_carry <= init_carry(i_op, i_carry_in);
            r_state <= RUN;
          end
        end

        RUN: begin
          r_c[r_idx] <= w_sum;
          r_carry    <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_carry_out <= w_cout;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        DONE: begin
          if (i_ready) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == IDLE);
  assign o_valid     = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_c         = W'(r_c);
  assign o_carry_out = r_carry_out;

endmodule

// File: tb/tb_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_adder_seq
//   Directed tests on an N=8/LIMBS=4 instance and randomized ADD/SUB traffic
//   with random downstream stalls on an N=64/LIMBS=4 instance, compared
//   against a wide-integer arithmetic model.
// -----------------------------------------------------------------------------
module tb_adder_seq;
  import adder_seq_pkg::*;

  localparam int NRAND = 3000;

  logic clk;
  logic rst_n;

  // N=8, LIMBS=4 instance (W=32)
  logic        i_valid8, o_ready8, i_cin8, o_valid8, i_ready8, o_cout8, o_busy8;
  op_t         i_op8;
  logic [31:0] i_a8, i_b8, o_c8;

  // N=64, LIMBS=4 instance (W=256)
  logic         i_valid64, o_ready64, i_cin64, o_valid64, i_ready64, o_cout64, o_busy64;
  op_t          i_op64;
  logic [255:0] i_a64, i_b64, o_c64;

  int n_checks = 0;
  int n_errors = 0;

  adder_seq #(.N(8), .LIMBS(4)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid8), .o_ready(o_ready8), .i_op(i_op8),
    .i_a(i_a8), .i_b(i_b8), .i_carry_in(i_cin8),
    .o_valid(o_valid8), .i_ready(i_ready8),
    .o_c(o_c8), .o_carry_out(o_cout8), .o_busy(o_busy8)
  );

  adder_seq #(.N(64), .LIMBS(4)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid64), .o_ready(o_ready64), .i_op(i_op64),
    .i_a(i_a64), .i_b(i_b64), .i_carry_in(i_cin64),
    .o_valid(o_valid64), .i_ready(i_ready64),
    .o_c(o_c64), .o_carry_out(o_cout64), .o_busy(o_busy64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide-integer arithmetic. SUB is a - b with carry-out
  // meaning "no borrow", i.e. a >= b.
  function automatic logic [256:0] ref_model(input op_t op, input logic [255:0] a,
                                             input logic [255:0] b, input logic cin);
    logic [256:0] r;
    if (op == ADD) begin
      r = {1'b0, a} + {1'b0, b} + 257'(cin);
    end else begin
      r[255:0] = a - b;
      r[256]   = (a >= b);
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    int mode;
    mode = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    if (mode == 0) v = '0;
    else if (mode == 1) v = '1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the 8-bit instance for exactly one accepting edge.
  task automatic start8(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
    int k;
    k = 0;
    while (!o_ready8 && k < 50) begin
      tick();
      k++;
    end
    check("ready_before_accept", 257'(o_ready8), 257'(1));
    i_valid8 = 1'b1;
    i_op8    = op;
    i_a8     = a;
    i_b8     = b;
    i_cin8   = cin;
    tick();
    // Scramble inputs after accept; they must not affect the result.
    i_valid8 = 1'b0;
    i_op8    = op_t'($urandom_range(0, 1));
    i_a8     = $urandom;
    i_b8     = $urandom;
    i_cin8   = ~cin;
  endtask

  // Returns the cycle index (accept cycle = 0) at which o_valid is first seen.
  task automatic wait_valid8(output int lat);
    lat = 1;
    while (!o_valid8 && lat < 50) begin
      tick();
      lat++;
    end
    check("valid_seen", 257'(o_valid8), 257'(1));
  endtask

  task automatic take8(output logic [32:0] r);
    r = {o_cout8, o_c8};
    i_ready8 = 1'b1;
    tick();
    i_ready8 = 1'b0;
    check("ready_after_take", 257'(o_ready8), 257'(1));
    check("valid_after_take", 257'(o_valid8), 257'(0));
  endtask

  initial begin
    int           lat;
    logic [32:0]  res;
    logic [31:0]  snap;
    op_t          op;
    logic [255:0] a, b;
    logic         cin;
    logic [256:0] expv;
    logic         got, checked;
    int           k;

    rst_n     = 1'b0;
    i_valid8  = 1'b0; i_op8  = ADD; i_a8  = '0; i_b8  = '0; i_cin8  = 1'b0; i_ready8  = 1'b0;
    i_valid64 = 1'b0; i_op64 = ADD; i_a64 = '0; i_b64 = '0; i_cin64 = 1'b0; i_ready64 = 1'b0;

    #1;
    check("rst_ready", 257'(o_ready8), 257'(1));
    check("rst_valid", 257'(o_valid8), 257'(0));
    check("rst_busy",  257'(o_busy8),  257'(0));
    check("rst_c",     257'(o_c8),     257'(0));
    check("rst_cout",  257'(o_cout8),  257'(0));
    check("rst_ready64", 257'(o_ready64), 257'(1));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Full carry ripple and accept-to-valid latency
    start8(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("run_busy",  257'(o_busy8),  257'(1));
    check("run_ready", 257'(o_ready8), 257'(0));
    check("run_valid", 257'(o_valid8), 257'(0));
    wait_valid8(lat);
    check("latency", 257'(lat), 257'(5));
    take8(res);
    check("add_ripple", 257'(res), 257'({1'b1, 32'h0000_0000}));

    // Carry-in honoured; i_ready high before o_valid is harmless
    i_ready8 = 1'b1;
    start8(ADD, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    i_ready8 = 1'b1;
    wait_valid8(lat);
    check("latency_ready_early", 257'(lat), 257'(5));
    take8(res);
    check("add_cin", 257'(res), 257'({1'b0, 32'h2222_2222}));

    // Subtraction with and without borrow; carry-in ignored
    start8(SUB, 32'h0000_0005, 32'h0000_0007, 1'b1);
    wait_valid8(lat);
    take8(res);
    check("sub_borrow", 257'(res), 257'({1'b0, 32'hFFFF_FFFE}));
    start8(SUB, 32'h0000_0007, 32'h0000_0005, 1'b0);
    wait_valid8(lat);
    take8(res);
    check("sub_noborrow", 257'(res), 257'({1'b1, 32'h0000_0002}));

    // Backpressure: DONE held for 10 cycles, request pulses ignored
    start8(ADD, 32'hA5A5_A5A5, 32'h0101_0101, 1'b0);
    wait_valid8(lat);
    snap = o_c8;
    check("bp_value", 257'({o_cout8, o_c8}), 257'({1'b0, 32'hA6A6_A6A6}));
    for (int i = 0; i < 10; i++) begin
      i_valid8 = i[0];
      i_a8     = $urandom;
      tick();
      check("bp_valid_held", 257'(o_valid8), 257'(1));
      check("bp_c_stable",   257'(o_c8),     257'(snap));
      check("bp_not_ready",  257'(o_ready8), 257'(0));
    end
    i_valid8 = 1'b0;
    take8(res);
    tick();
    check("bp_no_accept", 257'(o_busy8), 257'(0));

    // Asynchronous reset after two limbs of an operation with a live carry
    start8(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_ready", 257'(o_ready8), 257'(1));
    check("arst_valid", 257'(o_valid8), 257'(0));
    check("arst_busy",  257'(o_busy8),  257'(0));
    check("arst_c",     257'(o_c8),     257'(0));
    check("arst_cout",  257'(o_cout8),  257'(0));
    tick();
    rst_n = 1'b1;
    tick();
    start8(ADD, 32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_valid8(lat);
    check("post_rst_latency", 257'(lat), 257'(5));
    take8(res);
    check("post_rst_add", 257'(res), 257'({1'b0, 32'h0000_0002}));

    // Randomized traffic on the 256-bit instance with random stalls
    for (int t = 0; t < NRAND; t++) begin
      op   = op_t'($urandom_range(0, 1));
      a    = rnd256();
      b    = rnd256();
      cin  = 1'($urandom_range(0, 1));
      expv = ref_model(op, a, b, cin);
      k = 0;
      while (!o_ready64 && k < 20) begin
        tick();
        k++;
      end
      check("rand_ready", 257'(o_ready64), 257'(1));
      i_valid64 = 1'b1;
      i_op64    = op;
      i_a64     = a;
      i_b64     = b;
      i_cin64   = cin;
      tick();
      got     = 1'b0;
      checked = 1'b0;
      for (int k2 = 0; k2 < 100 && !got; k2++) begin
        i_ready64 = ($urandom_range(0, 3) != 0);
        i_valid64 = ($urandom_range(0, 3) == 0);
        i_op64    = op_t'($urandom_range(0, 1));
        i_a64     = rnd256();
        i_b64     = rnd256();
        i_cin64   = 1'($urandom_range(0, 1));
        if (o_valid64) begin
          if (!checked) begin
            check("rand_result", {o_cout64, o_c64}, expv);
            checked = 1'b1;
          end
          if (i_ready64) got = 1'b1;
        end
        tick();
      end
      i_valid64 = 1'b0;
      i_ready64 = 1'b0;
      check("rand_completed", 257'(got), 257'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
